// File: rtl/fish_sort_gate_pkg.sv
// Shared definitions for the fish sorting gate: FSM encoding, class indices
// and the default conveyor timing constants used at board level.
package fish_sort_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2
    } gate_state_t;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_1    = 2'd1;
    localparam logic [1:0] CLS_2    = 2'd2;
    localparam logic [1:0] CLS_3    = 2'd3;

    // Conveyor travel time and actuator dwell, in system clocks
    localparam int DEFAULT_DELAY = 1000;
    localparam int DEFAULT_PULSE = 500;

    // Map the three comparator flags to a class index; CLS_NONE unless exactly one is set
    function automatic logic [1:0] classify(input logic f1, input logic f2, input logic f3);
        logic [1:0] cls;
        cls = CLS_NONE;
        case ({f3, f2, f1})
            3'b001:  cls = CLS_1;
            3'b010:  cls = CLS_2;
            3'b100:  cls = CLS_3;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fish_sort_gate_sat_counter.sv
// CW-bit event counter that sticks at all-ones; a synchronous clear has
// priority over the increment.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fish_sort_gate.sv
// Fish sorting gate: counts each classified fish and drives the matching
// actuator one conveyor-travel delay later for a fixed pulse width.
module fish_sort_gate
    import fish_sort_gate_pkg::*;
#(
    parameter int CW    = 16,
    parameter int TW    = 16,
    parameter int DELAY = DEFAULT_DELAY,
    parameter int PULSE = DEFAULT_PULSE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          choise_valid,
    input  logic          choise_1,
    input  logic          choise_2,
    input  logic          choise_3,
    input  logic          cnt_clear,
    output logic          gate_1,
    output logic          gate_2,
    output logic          gate_3,
    output logic          busy,
    output logic [CW-1:0] count_1,
    output logic [CW-1:0] count_2,
    output logic [CW-1:0] count_3,
    output logic [CW-1:0] count_reject,
    output logic          overrun
);

    localparam logic [TW-1:0] DELAY_LD = TW'(DELAY - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE - 1);

    logic [1:0]  ev_cls;
    logic        ev_good;
    logic        ev_rej;

    gate_state_t state_q;
    logic [TW-1:0] timer_q;
    logic [1:0]  cls_q;
    logic [2:0]  gate_q;
    logic        busy_q;
    logic        overrun_q;
    logic        overrun_d;

    assign ev_cls  = classify(choise_1, choise_2, choise_3);
    assign ev_good = choise_valid && (ev_cls != CLS_NONE);
    assign ev_rej  = choise_valid && (ev_cls == CLS_NONE);

    sat_counter #(.CW(CW)) u_cnt_1 (
        .clk(clk), .rst_n(reset), .clr_i(cnt_clear),
        .inc_i(ev_good && (ev_cls == CLS_1)), .cnt_o(count_1)
    );
    sat_counter #(.CW(CW)) u_cnt_2 (
        .clk(clk), .rst_n(reset), .clr_i(cnt_clear),
        .inc_i(ev_good && (ev_cls == CLS_2)), .cnt_o(count_2)
    );
    sat_counter #(.CW(CW)) u_cnt_3 (
        .clk(clk), .rst_n(reset), .clr_i(cnt_clear),
        .inc_i(ev_good && (ev_cls == CLS_3)), .cnt_o(count_3)
    );
    sat_counter #(.CW(CW)) u_cnt_rej (
        .clk(clk), .rst_n(reset), .clr_i(cnt_clear),
        .inc_i(ev_rej), .cnt_o(count_reject)
    );

    // Overrun: a good event seen while the engine is still occupied (final FIRE cycle included)
    always_comb begin
        overrun_d = overrun_q;
        if (cnt_clear) begin
            overrun_d = 1'b0;
        end else if (ev_good && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    // Actuation engine: latch class, wait the travel delay, then hold the gate for the pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cls_q   <= CLS_NONE;
            gate_q  <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_good) begin
                        state_q <= ST_WAIT;
                        timer_q <= DELAY_LD;
                        cls_q   <= ev_cls;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (timer_q == '0) begin
                        state_q <= ST_FIRE;
                        timer_q <= PULSE_LD;
                        gate_q  <= {cls_q == CLS_3, cls_q == CLS_2, cls_q == CLS_1};
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_FIRE: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        gate_q  <= 3'b000;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    gate_q  <= 3'b000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gate_1  = gate_q[0];
    assign gate_2  = gate_q[1];
    assign gate_3  = gate_q[2];
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
